w_bus_sequencer: RTL and testbench

// - Bus-side controller for the W working register: the reader/writer counterpart of its tri-state A/B ports.
// - Accepts one operation request and drives the W output enables onto bus A and/or bus B.
// - Captures the bus values and presents them to the ALU as operands.
// - Waits for the ALU result, then strobes the W write enable with that result.
// - Sits between the instruction decoder (request side) and the W register/ALU in the structural datapath.

---
 rtl/w_bus_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_w_bus_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_bus_sequencer.sv
// Bus-side sequencer for the W register: drives W onto buses A/B, captures ALU operands, writes the result back.
// Optional feature macro WB_FORWARD_EN: forward the last written value from a shadow register instead of using the buses.
module w_bus_sequencer #(
  parameter int WIDTH    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rd_a,
  input  logic             req_rd_b,
  input  logic             req_wr,
  input  logic [WIDTH-1:0] bus_a_in,
  input  logic [WIDTH-1:0] bus_b_in,
  output logic             w_out_a_en,
  output logic             w_out_b_en,
  output logic             w_write_en,
  output logic [WIDTH-1:0] w_data_in,
  output logic             opnd_valid,
  output logic [WIDTH-1:0] opnd_a,
  output logic [WIDTH-1:0] opnd_b,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_CAPTURE,
    S_EXEC,
    S_WRITE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic             rd_a_q, rd_a_d;
  logic             rd_b_q, rd_b_d;
  logic             wr_q, wr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             out_a_en_q, out_a_en_d;
  logic             out_b_en_q, out_b_en_d;
  logic             write_en_q, write_en_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic             opnd_valid_q, opnd_valid_d;
  logic [WIDTH-1:0] opnd_a_q, opnd_a_d;
  logic [WIDTH-1:0] opnd_b_q, opnd_b_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             accept;

`ifdef WB_FORWARD_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             shadow_valid_q, shadow_valid_d;

  // The shadow mirrors whatever W was last written with.
  always_comb begin
    shadow_d       = write_en_q ? data_in_q : shadow_q;
    shadow_valid_d = shadow_valid_q | write_en_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end
`endif

  assign accept = req_valid && req_ready_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    rd_a_d    = rd_a_q;
    rd_b_d    = rd_b_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    data_in_d = data_in_q;
    opnd_a_d  = opnd_a_q;
    opnd_b_d  = opnd_b_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_a_d   = req_rd_a;
          rd_b_d   = req_rd_b;
          wr_d     = req_wr;
          opnd_a_d = '0;
          opnd_b_d = '0;
          if (req_rd_a || req_rd_b) begin
`ifdef WB_FORWARD_EN
            if (shadow_valid_q) begin
              state_d  = S_EXEC;
              opnd_a_d = req_rd_a ? shadow_q : '0;
              opnd_b_d = req_rd_b ? shadow_q : '0;
            end else begin
              state_d = S_DRIVE;
            end
`else
            state_d = S_DRIVE;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_DRIVE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // Buses have had a full cycle to settle; sample at the end of the second enable cycle.
        opnd_a_d = rd_a_q ? bus_a_in : '0;
        opnd_b_d = rd_b_q ? bus_b_in : '0;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = cnt_q + 8'd1;
        if (res_valid) begin
          cnt_d  = '0;
          done_d = 1'b1;
          if (wr_q) begin
            data_in_d = res_data;
            state_d   = S_WRITE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so that every output leaves a flop.
    out_a_en_d   = ((state_d == S_DRIVE) || (state_d == S_CAPTURE)) && rd_a_d;
    out_b_en_d   = ((state_d == S_DRIVE) || (state_d == S_CAPTURE)) && rd_b_d;
    write_en_d   = (state_d == S_WRITE);
    opnd_valid_d = (state_d == S_EXEC);
    req_ready_d  = (state_d == S_IDLE) && !done_d && !timeout_d;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      rd_a_q       <= 1'b0;
      rd_b_q       <= 1'b0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      out_a_en_q   <= 1'b0;
      out_b_en_q   <= 1'b0;
      write_en_q   <= 1'b0;
      data_in_q    <= '0;
      opnd_valid_q <= 1'b0;
      opnd_a_q     <= '0;
      opnd_b_q     <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_a_q       <= rd_a_d;
      rd_b_q       <= rd_b_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      out_a_en_q   <= out_a_en_d;
      out_b_en_q   <= out_b_en_d;
      write_en_q   <= write_en_d;
      data_in_q    <= data_in_d;
      opnd_valid_q <= opnd_valid_d;
      opnd_a_q     <= opnd_a_d;
      opnd_b_q     <= opnd_b_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign w_out_a_en  = out_a_en_q;
  assign w_out_b_en  = out_b_en_q;
  assign w_write_en  = write_en_q;
  assign w_data_in   = data_in_q;
  assign opnd_valid  = opnd_valid_q;
  assign opnd_a      = opnd_a_q;
  assign opnd_b      = opnd_b_q;
  assign done        = done_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_w_bus_sequencer.sv
// Self-checking bench for w_bus_sequencer: per-operation timeline model (cycle arithmetic) with random stimulus.
module tb_w_bus_sequencer;

  localparam int WIDTH    = 8;
  localparam int WAIT_MAX = 15;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_rd_a, req_rd_b, req_wr;
  logic [WIDTH-1:0] bus_a_in, bus_b_in;
  logic             w_out_a_en, w_out_b_en, w_write_en;
  logic [WIDTH-1:0] w_data_in, opnd_a, opnd_b;
  logic             opnd_valid, res_valid, done, timeout_err;
  logic [WIDTH-1:0] res_data;

  w_bus_sequencer #(.WIDTH(WIDTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_a(req_rd_a), .req_rd_b(req_rd_b), .req_wr(req_wr),
    .bus_a_in(bus_a_in), .bus_b_in(bus_b_in),
    .w_out_a_en(w_out_a_en), .w_out_b_en(w_out_b_en), .w_write_en(w_write_en),
    .w_data_in(w_data_in), .opnd_valid(opnd_valid), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .res_valid(res_valid), .res_data(res_data),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Expected outputs for the current cycle, written by the driver, read by the compare process.
  logic       exp_ready, exp_en_a, exp_en_b, exp_we, exp_ov, exp_done, exp_to, exp_full;
  logic [7:0] exp_opa, exp_opb, exp_wd;
  logic       chk_en = 1'b0;
  int         test_id = 0;
  int         cur_c = 0;
  logic [7:0] m_shadow = '0;
  logic       m_shadow_valid = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s test=%0d cycle=%0d got=%0h expected=%0h", name, test_id, cur_c, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("req_ready",   32'(req_ready),   32'(exp_ready));
      check("w_out_a_en",  32'(w_out_a_en),  32'(exp_en_a));
      check("w_out_b_en",  32'(w_out_b_en),  32'(exp_en_b));
      check("w_write_en",  32'(w_write_en),  32'(exp_we));
      check("opnd_valid",  32'(opnd_valid),  32'(exp_ov));
      check("done",        32'(done),        32'(exp_done));
      check("timeout_err", 32'(timeout_err), 32'(exp_to));
      if (exp_ov || exp_full) begin
        check("opnd_a", 32'(opnd_a), 32'(exp_opa));
        check("opnd_b", 32'(opnd_b), 32'(exp_opb));
      end
      if (exp_we || exp_full) check("w_data_in", 32'(w_data_in), 32'(exp_wd));

      // Hand-computed literal expectations for the directed scenarios.
      if (test_id == 1) begin
        if (cur_c == 1 || cur_c == 2) check("t1_en_a", 32'(w_out_a_en), 32'd1);
        if (cur_c == 3) begin
          check("t1_opnd_a", 32'(opnd_a), 32'h3C);
          check("t1_opnd_b", 32'(opnd_b), 32'h00);
        end
        if (cur_c == 4) begin
          check("t1_we",    32'(w_write_en), 32'd1);
          check("t1_done",  32'(done),       32'd1);
          check("t1_wdata", 32'(w_data_in),  32'h5A);
        end
        if (cur_c == 5) check("t1_ready", 32'(req_ready), 32'd1);
      end
      if (test_id == 2) begin
        if (cur_c == 1) check("t2_both_en", 32'(w_out_a_en & w_out_b_en), 32'd1);
        if (cur_c == 3) begin
          check("t2_opnd_a", 32'(opnd_a), 32'h11);
          check("t2_opnd_b", 32'(opnd_b), 32'h22);
        end
        if (cur_c == 5) begin
          check("t2_done", 32'(done),       32'd1);
          check("t2_we",   32'(w_write_en), 32'd0);
        end
      end
      if (test_id == 3) begin
        if (cur_c == 1) begin
          check("t3_ov",     32'(opnd_valid),              32'd1);
          check("t3_opnd_a", 32'(opnd_a),                  32'h00);
          check("t3_no_en",  32'(w_out_a_en | w_out_b_en), 32'd0);
        end
        if (cur_c == 2) check("t3_wdata", 32'(w_data_in), 32'h77);
      end
      if (test_id == 4) begin
        if (cur_c == 15) check("t4_to_early", 32'(timeout_err), 32'd0);
        if (cur_c == 16) begin
          check("t4_to", 32'(timeout_err), 32'd1);
          check("t4_we", 32'(w_write_en),  32'd0);
        end
        if (cur_c == 17) begin
          check("t4_ready", 32'(req_ready),   32'd1);
          check("t4_to_lo", 32'(timeout_err), 32'd0);
        end
      end
      if (test_id == 5 && cur_c == 16) begin
        check("t5_we",    32'(w_write_en),  32'd1);
        check("t5_to",    32'(timeout_err), 32'd0);
        check("t5_wdata", 32'(w_data_in),   32'h99);
      end
      if (test_id == 6 && cur_c == 3) begin
        check("t6_ready",  32'(req_ready),  32'd1);
        check("t6_en_a",   32'(w_out_a_en), 32'd0);
        check("t6_we",     32'(w_write_en), 32'd0);
        check("t6_opnd_a", 32'(opnd_a),     32'h00);
      end
`ifdef WB_FORWARD_EN
      if (test_id == 7 && cur_c == 1) begin
        check("t7_ov",     32'(opnd_valid), 32'd1);
        check("t7_opnd_a", 32'(opnd_a),     32'hA5);
        check("t7_en_a",   32'(w_out_a_en), 32'd0);
      end
`else
      if (test_id == 7) begin
        if (cur_c == 1) check("t7_en_a", 32'(w_out_a_en), 32'd1);
        if (cur_c == 3) check("t7_opnd_a", 32'(opnd_a), 32'h3C);
      end
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic noise();
    req_valid = 1'($urandom);
    req_rd_a  = 1'($urandom);
    req_rd_b  = 1'($urandom);
    req_wr    = 1'($urandom);
    bus_a_in  = 8'($urandom);
    bus_b_in  = 8'($urandom);
    res_valid = 1'($urandom);
    res_data  = 8'($urandom);
  endtask

  task automatic idle_noise();
    noise();
    req_valid = 1'b0;
  endtask

  task automatic set_idle(input logic full);
    exp_ready = 1'b1;
    exp_en_a  = 1'b0;
    exp_en_b  = 1'b0;
    exp_we    = 1'b0;
    exp_ov    = 1'b0;
    exp_done  = 1'b0;
    exp_to    = 1'b0;
    exp_full  = full;
    exp_opa   = '0;
    exp_opb   = '0;
    exp_wd    = '0;
  endtask

  task automatic idle_cycles(input int n, input logic full);
    for (int i = 0; i < n; i++) begin
      step();
      idle_noise();
      set_idle(full);
      cur_c++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_noise();
    m_shadow_valid = 1'b0;
    set_idle(1'b1);
    test_id = 0;
    cur_c = 0;
  endtask

  // One operation, entered and left in an idle cycle. r = EXEC cycle (1-based) carrying
  // res_valid, 0 for none; rst_at = operation cycle in which reset is driven, 0 for none.
  task automatic run_op(input int tid, input logic rd_a, input logic rd_b, input logic wr,
                        input int r, input int rst_at, input logic fixed,
                        input logic [7:0] fa, input logic [7:0] fb, input logic [7:0] fres,
                        input int gap);
    logic       fwd_hit, bus_path;
    int         e_start, e_end;
    logic [7:0] oa, ob, wd;
    fwd_hit = 1'b0;
`ifdef WB_FORWARD_EN
    fwd_hit = (rd_a | rd_b) & m_shadow_valid;
`endif
    bus_path = (rd_a | rd_b) & ~fwd_hit;
    e_start  = bus_path ? 3 : 1;
    e_end    = e_start + ((r != 0) ? r : WAIT_MAX) - 1;
    oa = (fwd_hit && rd_a) ? m_shadow : 8'h00;
    ob = (fwd_hit && rd_b) ? m_shadow : 8'h00;
    wd = 8'h00;

    test_id = tid;
    cur_c   = 0;
    noise();
    req_valid = 1'b1;
    req_rd_a  = rd_a;
    req_rd_b  = rd_b;
    req_wr    = wr;
    set_idle(exp_full);

    for (int c = 1; c <= e_end + 1; c++) begin
      step();
      if (reset) begin
        reset = 1'b0;
        idle_noise();
        m_shadow_valid = 1'b0;
        set_idle(1'b1);
        cur_c = c;
        return;
      end
      noise();
      if (fixed) begin
        bus_a_in = fa;
        bus_b_in = fb;
        res_data = fres;
      end
      if (c >= e_start && c <= e_end) res_valid = (r != 0) && (c == e_start + r - 1);
      if (c == 2 && bus_path) begin
        oa = rd_a ? bus_a_in : 8'h00;
        ob = rd_b ? bus_b_in : 8'h00;
      end
      if (c == e_end && r != 0) wd = res_data;
      reset     = (rst_at != 0) && (c == rst_at);
      exp_ready = 1'b0;
      exp_en_a  = bus_path && rd_a && (c <= 2);
      exp_en_b  = bus_path && rd_b && (c <= 2);
      exp_ov    = (c >= e_start) && (c <= e_end);
      exp_opa   = oa;
      exp_opb   = ob;
      exp_we    = (c == e_end + 1) && (r != 0) && wr;
      exp_done  = (c == e_end + 1) && (r != 0);
      exp_to    = (c == e_end + 1) && (r == 0);
      exp_wd    = wd;
      exp_full  = 1'b0;
      if (exp_we) begin
        m_shadow       = wd;
        m_shadow_valid = 1'b1;
      end
      cur_c = c;
    end

    step();
    if (reset) begin
      reset = 1'b0;
      m_shadow_valid = 1'b0;
      set_idle(1'b1);
    end else begin
      set_idle(1'b0);
    end
    idle_noise();
    cur_c = e_end + 2;
    idle_cycles(gap, exp_full);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_rd_a = 1'b0; req_rd_b = 1'b0; req_wr = 1'b0;
    bus_a_in = '0; bus_b_in = '0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    set_idle(1'b1);
    chk_en = 1'b1;
    idle_cycles(2, 1'b1);

    run_op(1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 8'h3C, 8'h00, 8'h5A, 1);
    do_reset();
    run_op(2, 1'b1, 1'b1, 1'b0, 2, 0, 1'b1, 8'h11, 8'h22, 8'h00, 1);
    do_reset();
    run_op(3, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 8'h00, 8'h00, 8'h77, 1);
    run_op(4, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 8'h00, 8'h00, 8'h00, 1);
    run_op(5, 1'b0, 1'b0, 1'b1, WAIT_MAX, 0, 1'b1, 8'h00, 8'h00, 8'h99, 1);
    run_op(6, 1'b1, 1'b0, 1'b1, 5, 2, 1'b1, 8'h3C, 8'h00, 8'h5A, 0);
    idle_cycles(1, 1'b1);
    run_op(0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 8'h00, 8'h00, 8'hA5, 0);
    run_op(7, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 8'h3C, 8'h00, 8'h5A, 1);

    for (int n = 0; n < 300; n++) begin
      int r, rst_at;
      r = ($urandom_range(0, 7) == 0) ? 0 :
          (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WAIT_MAX)) : int'($urandom_range(1, 3)));
      rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 6)) : 0;
      if ($urandom_range(0, 24) == 0) do_reset();
      run_op(0, 1'($urandom), 1'($urandom), 1'($urandom), r, rst_at, 1'b0,
             8'h00, 8'h00, 8'h00, int'($urandom_range(0, 2)));
    end

    idle_cycles(2, exp_full);
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
